// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the cache miss controller and lru_counters users.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HIT_UPD,
        VICTIM,
        WB_REQ,
        FILL_REQ,
        FILL_WAIT,
        INSTALL
    } ctrl_state_t;

    // Index widths never drop below one bit so degenerate sizes still give legal ports.
    function automatic int set_size(input int num_sets);
        return (num_sets > 1) ? $clog2(num_sets) : 1;
    endfunction

    function automatic int assoc_size(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// One-access-at-a-time cache controller: hit -> LRU update; miss -> victim, optional writeback,
// fill, tag install and LRU update.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter  int NUM_SETS   = 16,
    parameter  int ASSOC      = 4,
    parameter  int STAT_WIDTH = 16,
    localparam int SET_SIZE   = set_size(NUM_SETS),
    localparam int ASSOC_SIZE = assoc_size(ASSOC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SET_SIZE-1:0]   req_set,
    input  logic                  req_hit,
    input  logic [ASSOC_SIZE-1:0] req_hit_way,
    output logic [SET_SIZE-1:0]   lru_set,
    output logic [ASSOC_SIZE-1:0] lru_selected_way,
    output logic                  lru_process,
    input  logic [ASSOC_SIZE-1:0] lru_victim_way,
    input  logic                  victim_dirty,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ASSOC_SIZE-1:0] wb_way,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [ASSOC_SIZE-1:0] fill_way,
    input  logic                  fill_done,
    output logic                  tag_wr_en,
    output logic                  rsp_valid,
    output logic                  rsp_miss,
    output logic [ASSOC_SIZE-1:0] rsp_way,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
);

    ctrl_state_t           state_q, state_d;
    logic [SET_SIZE-1:0]   set_q;
    logic [ASSOC_SIZE-1:0] hit_way_q;
    logic [ASSOC_SIZE-1:0] victim_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // The victim is latched once; the LRU is untouched until INSTALL so it cannot move underneath us.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_q     <= '0;
            hit_way_q <= '0;
            victim_q  <= '0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                set_q     <= req_set;
                hit_way_q <= req_hit_way;
            end
            if (state_q == VICTIM)
                victim_q <= lru_victim_way;
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        lru_process      = 1'b0;
        lru_selected_way = '0;
        wb_valid         = 1'b0;
        fill_valid       = 1'b0;
        tag_wr_en        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_miss         = 1'b0;
        rsp_way          = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = req_hit ? HIT_UPD : VICTIM;
            end
            HIT_UPD: begin
                lru_process      = 1'b1;
                lru_selected_way = hit_way_q;
                rsp_valid        = 1'b1;
                rsp_way          = hit_way_q;
                state_d          = IDLE;
            end
            VICTIM:
                state_d = victim_dirty ? WB_REQ : FILL_REQ;
            WB_REQ: begin
                wb_valid = 1'b1;
                if (wb_ready)
                    state_d = FILL_REQ;
            end
            FILL_REQ: begin
                fill_valid = 1'b1;
                if (fill_ready)
                    state_d = FILL_WAIT;
            end
            FILL_WAIT:
                if (fill_done)
                    state_d = INSTALL;
            INSTALL: begin
                tag_wr_en        = 1'b1;
                lru_process      = 1'b1;
                lru_selected_way = victim_q;
                rsp_valid        = 1'b1;
                rsp_miss         = 1'b1;
                rsp_way          = victim_q;
                state_d          = IDLE;
            end
            default:
                state_d = IDLE;
        endcase
    end

    assign lru_set  = set_q;
    assign wb_way   = victim_q;
    assign fill_way = victim_q;

    sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q == HIT_UPD),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (state_q == INSTALL),
        .count (miss_count)
    );

endmodule
